// File: rtl/alu_ctrl_issue.sv
// rtl/alu_ctrl_issue.sv - MIPS execute-stage ALU control/operand issue unit with 2-entry skid buffer
module alu_ctrl_issue #(
  parameter int CANT_BITS_ALU_CONTROL = 4,
  parameter int CANT_BITS_DATO        = 32,
  parameter int CANT_BITS_CONTADOR    = 8
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [5:0]                       i_opcode,
  input  logic [5:0]                       i_funct,
  input  logic [4:0]                       i_shamt,
  input  logic [15:0]                      i_inmediato,
  input  logic [CANT_BITS_DATO-1:0]        i_rs_data,
  input  logic [CANT_BITS_DATO-1:0]        i_rt_data,
  input  logic                             i_flush,
  input  logic                             i_ready,
  output logic                             o_valid,
  output logic [CANT_BITS_ALU_CONTROL-1:0] o_ALUCtrl,
  output logic [CANT_BITS_DATO-1:0]        o_datoA,
  output logic [CANT_BITS_DATO-1:0]        o_datoB,
  output logic                             o_ilegal,
  output logic [CANT_BITS_CONTADOR-1:0]    o_cont_ilegal
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t                           state;
  logic [CANT_BITS_ALU_CONTROL-1:0] dec_code, skid_code;
  logic [CANT_BITS_DATO-1:0]        dec_a, dec_b, skid_a, skid_b;
  logic                             dec_ilegal, skid_ilegal;
  logic [CANT_BITS_DATO-1:0]        imm_sext, imm_zext, shamt_zext, rs_sh_zext;
  logic                             up_xfer, dn_xfer;

  assign imm_sext   = {{(CANT_BITS_DATO-16){i_inmediato[15]}}, i_inmediato};
  assign imm_zext   = {{(CANT_BITS_DATO-16){1'b0}}, i_inmediato};
  assign shamt_zext = {{(CANT_BITS_DATO-5){1'b0}}, i_shamt};
  assign rs_sh_zext = {{(CANT_BITS_DATO-5){1'b0}}, i_rs_data[4:0]};

  assign up_xfer = i_valid & o_ready & ~i_flush;
  assign dn_xfer = o_valid & i_ready;

  // Unrecognised encodings fall through to the ADD-like default with o_ilegal set.
  always_comb begin
    dec_code   = 4'b0010;
    dec_a      = i_rs_data;
    dec_b      = i_rt_data;
    dec_ilegal = 1'b0;
    case (i_opcode)
      6'b000000: begin
        case (i_funct)
          6'b000000: begin dec_code = 4'b1011; dec_a = i_rt_data; dec_b = shamt_zext; end
          6'b000010: begin dec_code = 4'b1100; dec_a = i_rt_data; dec_b = shamt_zext; end
          6'b000011: begin dec_code = 4'b1101; dec_a = i_rt_data; dec_b = shamt_zext; end
          6'b000100: begin dec_code = 4'b1011; dec_a = i_rt_data; dec_b = rs_sh_zext; end
          6'b000110: begin dec_code = 4'b1100; dec_a = i_rt_data; dec_b = rs_sh_zext; end
          6'b000111: begin dec_code = 4'b1101; dec_a = i_rt_data; dec_b = rs_sh_zext; end
          6'b100000, 6'b100001: dec_code = 4'b0010;
          6'b100010, 6'b100011: dec_code = 4'b0110;
          6'b100100: dec_code = 4'b0000;
          6'b100101: dec_code = 4'b0001;
          6'b100110: dec_code = 4'b1001;
          6'b100111: dec_code = 4'b1010;
          6'b101010: dec_code = 4'b0111;
          6'b001000, 6'b001001: begin dec_code = 4'b1110; dec_b = '0; end
          default: dec_ilegal = 1'b1;
        endcase
      end
      6'b001000, 6'b001001: begin dec_code = 4'b0010; dec_b = imm_sext; end
      6'b001010: begin dec_code = 4'b0111; dec_b = imm_sext; end
      6'b001100: begin dec_code = 4'b0000; dec_b = imm_zext; end
      6'b001101: begin dec_code = 4'b0001; dec_b = imm_zext; end
      6'b001110: begin dec_code = 4'b1001; dec_b = imm_zext; end
      6'b001111: begin dec_code = 4'b1000; dec_a = '0; dec_b = imm_zext; end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100111,
      6'b101000, 6'b101001, 6'b101011: begin dec_code = 4'b0010; dec_b = imm_sext; end
      6'b000100, 6'b000101: dec_code = 4'b0110;
      default: dec_ilegal = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= EMPTY;
      o_ready     <= 1'b1;
      o_valid     <= 1'b0;
      o_ilegal    <= 1'b0;
      o_ALUCtrl   <= '0;
      o_datoA     <= '0;
      o_datoB     <= '0;
      skid_code   <= '0;
      skid_a      <= '0;
      skid_b      <= '0;
      skid_ilegal <= 1'b0;
    end else if (i_flush) begin
      state       <= EMPTY;
      o_ready     <= 1'b1;
      o_valid     <= 1'b0;
      o_ilegal    <= 1'b0;
      skid_code   <= '0;
      skid_a      <= '0;
      skid_b      <= '0;
      skid_ilegal <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (up_xfer) begin
            state     <= BUSY;
            o_valid   <= 1'b1;
            o_ALUCtrl <= dec_code;
            o_datoA   <= dec_a;
            o_datoB   <= dec_b;
            o_ilegal  <= dec_ilegal;
          end
        end
        BUSY: begin
          if (up_xfer && dn_xfer) begin
            o_ALUCtrl <= dec_code;
            o_datoA   <= dec_a;
            o_datoB   <= dec_b;
            o_ilegal  <= dec_ilegal;
          end else if (dn_xfer) begin
            state    <= EMPTY;
            o_valid  <= 1'b0;
            o_ilegal <= 1'b0;
          end else if (up_xfer) begin
            // Main register is stalled, so the new bundle parks in the skid entry.
            state       <= FULL;
            o_ready     <= 1'b0;
            skid_code   <= dec_code;
            skid_a      <= dec_a;
            skid_b      <= dec_b;
            skid_ilegal <= dec_ilegal;
          end
        end
        FULL: begin
          if (dn_xfer) begin
            state     <= BUSY;
            o_ready   <= 1'b1;
            o_ALUCtrl <= skid_code;
            o_datoA   <= skid_a;
            o_datoB   <= skid_b;
            o_ilegal  <= skid_ilegal;
          end
        end
        default: begin
          state   <= EMPTY;
          o_ready <= 1'b1;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_cont_ilegal <= '0;
    end else if (up_xfer && dec_ilegal && (o_cont_ilegal != {CANT_BITS_CONTADOR{1'b1}})) begin
      o_cont_ilegal <= o_cont_ilegal + 1'b1;
    end
  end

endmodule

// File: doc/alu_ctrl_issue.md
Name: alu_ctrl_issue

Overview:
- Execute-stage issue unit that drives the ALU control/operand interface.
- Decodes MIPS opcode/funct into the 4-bit ALU control code and builds operand A/B: shamt vs register shift amounts, sign/zero immediate extension, LUI, branch compare, JR/JALR pass-through.
- Sits between the ID/EX register file read and the ALU.
- Provides a valid/ready handshake with a 2-entry skid buffer, so back-pressure from the ALU consumer is fully registered.

Parameters:
CANT_BITS_ALU_CONTROL, 4, width of the ALU control code
CANT_BITS_DATO, 32, datapath width
CANT_BITS_CONTADOR, 8, width of the saturating illegal-instruction counter

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_valid  in  1  upstream instruction valid
o_ready  out  1  upstream may present the next instruction
i_opcode  in  6  instruction[31:26]
i_funct  in  6  instruction[5:0]
i_shamt  in  5  instruction[10:6]
i_inmediato  in  16  instruction[15:0]
i_rs_data  in  CANT_BITS_DATO  rs register value
i_rt_data  in  CANT_BITS_DATO  rt register value
i_flush  in  1  discard all buffered and incoming instructions
i_ready  in  1  downstream ALU stage accepts
o_valid  out  1  output bundle valid
o_ALUCtrl  out  CANT_BITS_ALU_CONTROL  ALU control code
o_datoA  out  CANT_BITS_DATO  operand A
o_datoB  out  CANT_BITS_DATO  operand B
o_ilegal  out  1  current output instruction was not recognised
o_cont_ilegal  out  CANT_BITS_CONTADOR  saturating count of accepted illegal instructions

Behaviour:
Reset and handshake
- Reset is asynchronous and active-low: i_reset=0 immediately clears o_valid, o_ilegal, o_ALUCtrl, o_datoA, o_datoB, o_cont_ilegal and the skid entry; o_ready=1.
- Transfers: upstream transfer = i_valid & o_ready; downstream transfer = o_valid & i_ready.
- Storage is one main output register plus one skid register. o_ready = !skid_full, registered.
- Latency: a decoded bundle appears on outputs 1 cycle after upstream transfer when the main register is empty or draining.
- States: EMPTY (main empty) -> BUSY on accept. BUSY stays BUSY on accept+drain, -> EMPTY on drain only, -> FULL on accept without drain (bundle goes to skid). FULL -> BUSY on drain (skid moves to main).
- Order is preserved; no bundle is duplicated or dropped.
- Outputs hold stable while o_valid & !i_ready.

Flush
- i_flush=1 (synchronous) clears o_valid, o_ilegal and the skid entry, and ignores the same-cycle upstream input; next state is EMPTY.
- o_cont_ilegal is not cleared by flush.

R-type decode (opcode 000000), code / A / B:
- SLL 000000: 1011 / rt / zext(shamt).
- SRL 000010: 1100 / rt / zext(shamt).
- SRA 000011: 1101 / rt / zext(shamt).
- SLLV 000100, SRLV 000110, SRAV 000111: same codes / rt / zext(rs[4:0]).
- ADD 100000, ADDU 100001: 0010 / rs / rt.
- SUB 100010, SUBU 100011: 0110 / rs / rt.
- AND 100100: 0000. OR 100101: 0001. XOR 100110: 1001. NOR 100111: 1010. SLT 101010: 0111. All with A=rs, B=rt.
- JR 001000, JALR 001001: 1110 / rs / 0.

I-type decode, code / B (A=rs unless noted):
- ADDI 001000, ADDIU 001001: 0010 / sext(imm).
- SLTI 001010: 0111 / sext(imm).
- ANDI 001100: 0000 / zext(imm).
- ORI 001101: 0001 / zext(imm).
- XORI 001110: 1001 / zext(imm).
- LUI 001111: 1000 / zext(imm), A=0.
- Loads 100000, 100001, 100011, 100100, 100101, 100111 and stores 101000, 101001, 101011: 0010 / sext(imm).
- BEQ 000100, BNE 000101: 0110 / rt.

Illegal instructions
- Any other opcode/funct: code 0010, A=rs, B=rt, o_ilegal=1.
- o_cont_ilegal increments on each upstream transfer of an illegal instruction and saturates at all-ones.
- Flush-cycle inputs are not counted.

Widths
- sext replicates imm[15] to CANT_BITS_DATO; zext pads with zeros.

Test Plan:
- Reset mid-stream: i_reset low while FULL -> o_valid=0, o_cont_ilegal=0, o_ready=1 immediately; no stale bundle emitted after release.
- ADDI rs=0x00000005, imm=0xFFFE with i_ready=1 -> 1 cycle later o_valid=1, o_ALUCtrl=0010, A=0x00000005, B=0xFFFFFFFE. ORI imm=0x8000 -> B=0x00008000. LUI imm=0x1234 -> code 1000, A=0, B=0x00001234.
- SLL shamt=4, rt=0x1 -> code 1011, A=0x1, B=4. SRAV rs=0x00000123 -> B=0x00000003.
- Back-pressure: i_ready=0 while sending ADD, SUB, AND back-to-back -> o_ready drops after 2 accepted, outputs hold ADD. Then i_ready=1 -> ADD, SUB, AND emitted in order, one per cycle, no loss.
- Flush while FULL plus same-cycle upstream valid -> next cycle o_valid=0, o_ready=1; the incoming instruction never appears.
- 300 illegal opcodes (e.g. 111111) -> each o_ilegal=1, code 0010; o_cont_ilegal saturates at 255. A flushed illegal is not counted.
